rs_nway: RTL

Parametrised N-way reservation station that succeeds the fixed 2-way `rs_super`. It sits between dispatch and issue in the out-of-order core. Each cycle it accepts up to WAYS renamed instructions, and wakes up waiting operands from CDB_WIDTH broadcast tags, including same-cycle bypass on dispatch. It selects up to WAYS ready entries oldest-first, with per-lane issue back-pressure and a global squash.

---
 rtl/rs_nway_pkg.sv | 70 +++++++
 rtl/rs_nway_age_select.sv | 35 +++
 rtl/rs_nway.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rs_nway_pkg.sv
// -----------------------------------------------------------------------------
// rs_nway_pkg
// Shared types for the N-way reservation station: dispatch/issue packet
// layouts, ALU function encoding, the stored entry payload and the
// functional-unit class decode applied at dispatch.
// -----------------------------------------------------------------------------
package rs_nway_pkg;

  localparam int PREG_IDX_WIDTH = 6;
  localparam int NUM_RS_ENTRIES = 16;
  localparam int SCALAR_WIDTH   = 32;

  typedef logic [SCALAR_WIDTH-1:0] INST;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } ALU_FUNC;

  typedef enum logic [1:0] {FU_ALU, FU_MULT, FU_LSQ} fu_class_e;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] prega_idx;
    logic                      prega_ready;
    logic [PREG_IDX_WIDTH-1:0] pregb_idx;
    logic                      pregb_ready;
    logic [PREG_IDX_WIDTH-1:0] pdest_idx;
    logic                      wr_mem;
    logic                      rd_mem;
    ALU_FUNC                   alu_func;
    INST                       inst;
  } DP_RS_PACKET;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] prega_idx;
    logic [PREG_IDX_WIDTH-1:0] pregb_idx;
    logic [PREG_IDX_WIDTH-1:0] pdest_idx;
    logic                      wr_mem;
    logic                      rd_mem;
    logic                      alu_ready;
    logic                      mult_ready;
    logic                      lsq_ready;
    ALU_FUNC                   alu_func;
    INST                       inst;
  } RS_IS_PACKET;

  // Payload held per station entry; valid/ready bits live in separate
  // reset flops in the top level.
  typedef struct packed {
    logic [PREG_IDX_WIDTH-1:0] prega_idx;
    logic [PREG_IDX_WIDTH-1:0] pregb_idx;
    logic [PREG_IDX_WIDTH-1:0] pdest_idx;
    logic                      wr_mem;
    logic                      rd_mem;
    ALU_FUNC                   alu_func;
    INST                       inst;
    fu_class_e                 fu;
  } rs_entry_t;

  // Memory ops go to the LSQ regardless of alu_func, so that test comes first.
  function automatic fu_class_e fu_decode(input logic wr_mem, input logic rd_mem,
                                          input ALU_FUNC f);
    if (wr_mem || rd_mem) return FU_LSQ;
    if (f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return FU_MULT;
    return FU_ALU;
  endfunction

endpackage

// File: rtl/rs_nway_age_select.sv
// -----------------------------------------------------------------------------
// rs_age_select
// Oldest-first picker. Returns a one-hot mask of the eligible, non-excluded
// entry that no other candidate is older than.
//   eligible_i : entries that are valid with both operands ready
//   older_i    : age matrix, older_i[i][j] = 1 when i was allocated before j
//   excl_i     : entries already claimed by lower-numbered issue lanes
//   pick_o     : one-hot pick (all zero when no candidate)
// -----------------------------------------------------------------------------
module rs_age_select #(
  parameter int ENTRIES = 16
) (
  input  logic [ENTRIES-1:0]              eligible_i,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] older_i,
  input  logic [ENTRIES-1:0]              excl_i,
  output logic [ENTRIES-1:0]              pick_o
);

  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] blocked;

  always_comb begin
    cand    = eligible_i & ~excl_i;
    blocked = '0;
    pick_o  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      // An entry loses if any other candidate is older than it.
      for (int j = 0; j < ENTRIES; j++) begin
        if (cand[j] && older_i[j][i]) blocked[i] = 1'b1;
      end
      pick_o[i] = cand[i] & ~blocked[i];
    end
  end

endmodule

// File: rtl/rs_nway.sv
// -----------------------------------------------------------------------------
// rs_nway
// N-way reservation station between dispatch and issue.
//   clock, reset       : clock; asynchronous active-low reset
//   rs_packet_in[WAYS] : renamed dispatch packets
//   cdb_valid/cdb_tag  : CDB broadcast ports used for operand wakeup
//   squash             : flush every entry at the next edge
//   issue_ready[WAYS]  : downstream accepts lane k this cycle
//   rs_packet_out[WAYS]: issue packets, combinational from registered state
//   rs_full[WAYS]      : lane k must not dispatch when set
//   free_count         : registered number of free entries
// -----------------------------------------------------------------------------
module rs_nway
  import rs_nway_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int ENTRIES   = NUM_RS_ENTRIES,
  parameter int CDB_WIDTH = WAYS,
  parameter int PREG_W    = PREG_IDX_WIDTH,
  parameter int CNT_W     = $clog2(ENTRIES + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  DP_RS_PACKET                      rs_packet_in [WAYS],
  input  logic [CDB_WIDTH-1:0]             cdb_valid,
  input  logic [CDB_WIDTH-1:0][PREG_W-1:0] cdb_tag,
  input  logic                             squash,
  input  logic [WAYS-1:0]                  issue_ready,
  output RS_IS_PACKET                      rs_packet_out [WAYS],
  output logic [WAYS-1:0]                  rs_full,
  output logic [CNT_W-1:0]                 free_count
);

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0]              rdya_q, rdya_d, rdyb_q, rdyb_d;
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;
  logic [CNT_W-1:0]                free_count_q, free_count_d;
  rs_entry_t                       ent_q [ENTRIES];

  logic [ENTRIES-1:0]              eligible, wake_a, wake_b;
  logic [WAYS-1:0][ENTRIES-1:0]    avail, alloc_oh, excl, pick_oh;
  logic [WAYS-1:0]                 accept, issue_fire;
  logic [CNT_W-1:0]                n_alloc, n_issue;
  rs_entry_t                       new_ent [WAYS];

  function automatic logic cdb_match(input logic [PREG_W-1:0] tag,
                                     input logic [CDB_WIDTH-1:0] vld,
                                     input logic [CDB_WIDTH-1:0][PREG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) hit |= vld[c] && (tags[c] == tag);
    return hit;
  endfunction

  // Eligibility uses stored ready bits only: a wakeup this cycle counts next cycle.
  assign eligible   = valid_q & rdya_q & rdyb_q;
  assign free_count = free_count_q;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ent
    assign wake_a[gi] = cdb_match(ent_q[gi].prega_idx, cdb_valid, cdb_tag);
    assign wake_b[gi] = cdb_match(ent_q[gi].pregb_idx, cdb_valid, cdb_tag);
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
    // Free slots come from the registered valid mask only, so a slot freed
    // by issue this cycle is reused no earlier than next cycle.
    if (gi == 0) begin : g_first
      assign avail[gi] = ~valid_q;
      assign excl[gi]  = '0;
    end else begin : g_rest
      assign avail[gi] = avail[gi-1] & ~alloc_oh[gi-1];
      assign excl[gi]  = excl[gi-1] | pick_oh[gi-1];
    end
    assign rs_full[gi]    = (free_count_q <= CNT_W'(gi));
    assign accept[gi]     = rs_packet_in[gi].valid & ~rs_full[gi];
    // Isolate the lowest set bit of the still-available mask.
    assign alloc_oh[gi]   = accept[gi] ? (avail[gi] & (~avail[gi] + ENTRIES'(1))) : '0;
    assign issue_fire[gi] = (|pick_oh[gi]) & issue_ready[gi];

    rs_age_select #(.ENTRIES(ENTRIES)) u_sel (
      .eligible_i (eligible),
      .older_i    (older_q),
      .excl_i     (excl[gi]),
      .pick_o     (pick_oh[gi])
    );
  end

  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      new_ent[k].prega_idx = rs_packet_in[k].prega_idx;
      new_ent[k].pregb_idx = rs_packet_in[k].pregb_idx;
      new_ent[k].pdest_idx = rs_packet_in[k].pdest_idx;
      new_ent[k].wr_mem    = rs_packet_in[k].wr_mem;
      new_ent[k].rd_mem    = rs_packet_in[k].rd_mem;
      new_ent[k].alu_func  = rs_packet_in[k].alu_func;
      new_ent[k].inst      = rs_packet_in[k].inst;
      new_ent[k].fu        = fu_decode(rs_packet_in[k].wr_mem, rs_packet_in[k].rd_mem,
                                       rs_packet_in[k].alu_func);
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdya_d  = rdya_q | wake_a;
    rdyb_d  = rdyb_q | wake_b;
    older_d = older_q;
    n_alloc = '0;
    n_issue = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (issue_fire[k]) begin
        valid_d = valid_d & ~pick_oh[k];
        n_issue = n_issue + CNT_W'(1);
      end
      if (accept[k]) n_alloc = n_alloc + CNT_W'(1);
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_oh[k][i]) begin
          valid_d[i] = 1'b1;
          rdya_d[i]  = rs_packet_in[k].prega_ready |
                       cdb_match(rs_packet_in[k].prega_idx, cdb_valid, cdb_tag);
          rdyb_d[i]  = rs_packet_in[k].pregb_ready |
                       cdb_match(rs_packet_in[k].pregb_idx, cdb_valid, cdb_tag);
          // New entry is younger than everything resident and everything
          // taken by lower lanes this cycle, which is exactly ~avail[k].
          older_d[i] = '0;
          for (int j = 0; j < ENTRIES; j++) older_d[j][i] = ~avail[k][j];
        end
      end
    end
    free_count_d = free_count_q - n_alloc + n_issue;
    if (squash) begin
      valid_d      = '0;
      free_count_d = CNT_W'(ENTRIES);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      rdya_q       <= '0;
      rdyb_q       <= '0;
      older_q      <= '0;
      free_count_q <= CNT_W'(ENTRIES);
    end else begin
      valid_q      <= valid_d;
      rdya_q       <= rdya_d;
      rdyb_q       <= rdyb_d;
      older_q      <= older_d;
      free_count_q <= free_count_d;
    end
  end

  // Payload needs no reset: it is only visible through a valid entry.
  always_ff @(posedge clock) begin
    for (int k = 0; k < WAYS; k++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_oh[k][i]) ent_q[i] <= new_ent[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      rs_packet_out[k] = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (pick_oh[k][i]) begin
          rs_packet_out[k].valid      = 1'b1;
          rs_packet_out[k].prega_idx  = ent_q[i].prega_idx;
          rs_packet_out[k].pregb_idx  = ent_q[i].pregb_idx;
          rs_packet_out[k].pdest_idx  = ent_q[i].pdest_idx;
          rs_packet_out[k].wr_mem     = ent_q[i].wr_mem;
          rs_packet_out[k].rd_mem     = ent_q[i].rd_mem;
          rs_packet_out[k].alu_ready  = (ent_q[i].fu == FU_ALU);
          rs_packet_out[k].mult_ready = (ent_q[i].fu == FU_MULT);
          rs_packet_out[k].lsq_ready  = (ent_q[i].fu == FU_LSQ);
          rs_packet_out[k].alu_func   = ent_q[i].alu_func;
          rs_packet_out[k].inst       = ent_q[i].inst;
        end
      end
    end
  end

endmodule
